// File: rtl/cpu_mc_param.sv
// Multi-cycle 16-register CPU with parameterised data/address widths.
// One instruction moves through FETCH, DECODE, EXEC and optionally MEM/WB.
module cpu_mc_param #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 16,
   parameter int DA_W   = 16
) (
   input  logic              clk,
   input  logic              pc_reset,
   input  logic              run,
   input  logic [DATA_W-1:0] initial_input,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              imem_ready,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DA_W-1:0]   dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic [DATA_W-1:0] result_reg,
   output logic              halted,
   output logic              busy,
   output logic [2:0]        state_dbg
);

   // Memory handshakes: req is held with stable addr/data until the edge
   // where ready=1 completes the access; ready outside FETCH/MEM is ignored.
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_LSL  = 4'h5;
   localparam logic [3:0] OP_LSR  = 4'h6;
   localparam logic [3:0] OP_LDR  = 4'h7;
   localparam logic [3:0] OP_STR  = 4'h8;
   localparam logic [3:0] OP_BEQ  = 4'h9;
   localparam logic [3:0] OP_B    = 4'hA;
   localparam logic [3:0] OP_BL   = 4'hB;
   localparam logic [3:0] OP_BR   = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hD;

   state_t state, state_nxt;

   logic [DATA_W-1:0] regs [16];
   logic [PC_W-1:0]   pc, pc_tgt, pc_inc, pc_exec, b_tgt, imm4_p, imm8_p;
   logic [15:0]       ir;
   logic [DATA_W-1:0] opa, opb, res, alu, imm4_d;
   logic [3:0]        op, wb_dst;

   assign op     = ir[15:12];
   assign pc_inc = pc + PC_W'(1);
   assign imm4_d = DATA_W'($signed(ir[3:0]));
   assign imm4_p = PC_W'($signed(ir[3:0]));
   assign imm8_p = PC_W'($signed(ir[11:4]));
   assign wb_dst = (op <= OP_OR || op == OP_BL) ? ir[3:0] : ir[7:4];

   // Absolute jump keeps the page bits of pc+1 above the 12-bit field.
   generate
      if (PC_W > 12) begin : g_b_page
         assign b_tgt = {pc_inc[PC_W-1:12], ir[11:0]};
      end else begin : g_b_flat
         assign b_tgt = ir[11:0];
      end
   endgenerate

   always_comb begin
      alu = '0;
      case (op)
         4'h0:                  alu = opa + opb;
         4'h1:                  alu = opa - opb;
         4'h2:                  alu = opa & opb;
         OP_OR:                 alu = opa | opb;
         4'h4, OP_LDR, OP_STR:  alu = opa + imm4_d;
         OP_LSL:                alu = opa << ir[3:0];
         OP_LSR:                alu = opa >> ir[3:0];
         OP_BL:                 alu = DATA_W'(pc_inc);
         default:               alu = '0;
      endcase
   end

   always_comb begin
      pc_exec = pc_inc;
      case (op)
         OP_BEQ:  if (opa == opb) pc_exec = pc_inc + imm4_p;
         OP_B:    pc_exec = b_tgt;
         OP_BR:   pc_exec = opa[PC_W-1:0];
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      halted    = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (run) state_nxt = S_FETCH;
         end
         S_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
            if (run) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            if (op == OP_LDR || op == OP_STR)  state_nxt = S_MEM;
            else if (op <= OP_LSR || op == OP_BL) state_nxt = S_WB;
            else if (op == OP_HALT)            state_nxt = S_HALT;
            else                               state_nxt = S_FETCH;
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op == OP_STR);
            if (dmem_ready) state_nxt = (op == OP_STR) ? S_FETCH : S_WB;
         end
         S_WB:    state_nxt = S_FETCH;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) begin
         pc     <= '0;
         pc_tgt <= '0;
         ir     <= '0;
         opa    <= '0;
         opb    <= '0;
         res    <= '0;
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALT: begin
               if (run) begin
                  regs[1] <= initial_input;
                  pc      <= '0;
               end
            end
            S_FETCH: if (imem_ready) ir <= imem_rdata;
            S_DECODE: begin
               opa <= regs[ir[11:8]];
               opb <= regs[ir[7:4]];
            end
            S_EXEC: begin
               res    <= alu;
               pc_tgt <= pc_inc + imm8_p;
               if (state_nxt == S_FETCH || state_nxt == S_HALT) pc <= pc_exec;
            end
            S_MEM: begin
               if (dmem_ready) begin
                  if (op == OP_STR) pc  <= pc_inc;
                  else              res <= dmem_rdata;
               end
            end
            S_WB: begin
               if (wb_dst != 4'd0) regs[wb_dst] <= res;
               pc <= (op == OP_BL) ? pc_tgt : pc_inc;
            end
            default: ;
         endcase
      end
   end

   assign imem_addr  = pc;
   assign dmem_addr  = res[DA_W-1:0];
   assign dmem_wdata = opb;
   assign result_reg = regs[2];
   assign state_dbg  = state;

endmodule

// File: tb/tb_cpu_mc_param.sv
// Bench for cpu_mc_param: directed programs plus random programs checked
// against an instruction-level model with wait-state accounting.
module tb_cpu_mc_param;

   logic        clk = 1'b0;
   logic        pc_reset = 1'b1;
   logic        run = 1'b0;
   logic [15:0] initial_input = '0;
   logic        imem_req, dmem_req, dmem_we, halted, busy;
   logic [15:0] imem_addr, dmem_addr, dmem_wdata, result_reg;
   logic [15:0] imem_rdata = '0;
   logic [15:0] dmem_rdata = '0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic [2:0]  state_dbg;

   logic        run32 = 1'b0;
   logic [31:0] init32 = '0;
   logic        imem_req32, dmem_req32, dmem_we32, halted32, busy32;
   logic [15:0] imem_addr32, dmem_addr32, imem_rdata32;
   logic [31:0] dmem_wdata32, result32;
   logic [2:0]  state_dbg32;

   logic [15:0] imem [256];
   logic [15:0] dmem [256];
   logic [15:0] imem32 [16];
   logic [15:0] m_reg [16];
   logic [15:0] m_mem [256];
   int          m_cycles;

   int n_checks = 0;
   int n_fail = 0;
   int i_max = 0, d_max = 0, d_fixed = 0;
   int i_left = -1, d_left = -1;
   int waits = 0;
   bit noise = 1'b0;
   int dreq_len = 0;
   int dlens[$];

   always #5 clk = ~clk;

   cpu_mc_param #(.DATA_W(16), .PC_W(16), .DA_W(16)) dut (
      .clk(clk), .pc_reset(pc_reset), .run(run), .initial_input(initial_input),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_ready(dmem_ready), .result_reg(result_reg), .halted(halted),
      .busy(busy), .state_dbg(state_dbg)
   );

   assign imem_rdata32 = imem32[imem_addr32[3:0]];

   cpu_mc_param #(.DATA_W(32), .PC_W(16), .DA_W(16)) dut32 (
      .clk(clk), .pc_reset(pc_reset), .run(run32), .initial_input(init32),
      .imem_req(imem_req32), .imem_addr(imem_addr32), .imem_rdata(imem_rdata32),
      .imem_ready(1'b1), .dmem_req(dmem_req32), .dmem_we(dmem_we32),
      .dmem_addr(dmem_addr32), .dmem_wdata(dmem_wdata32), .dmem_rdata(32'h0),
      .dmem_ready(1'b1), .result_reg(result32), .halted(halted32),
      .busy(busy32), .state_dbg(state_dbg32)
   );

   // Memory responders: pick a wait count per access, noise when idle.
   always @(negedge clk) begin
      if (imem_req) begin
         if (i_left < 0) i_left = $urandom_range(0, i_max);
         if (i_left > 0) begin
            imem_ready = 1'b0;
            i_left--;
            waits++;
         end else begin
            imem_ready = 1'b1;
            imem_rdata = imem[imem_addr[7:0]];
         end
      end else begin
         i_left = -1;
         imem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         imem_rdata = noise ? 16'($urandom()) : 16'h0;
      end
      if (dmem_req) begin
         if (d_left < 0) begin
            if (d_fixed >= 0) d_left = d_fixed;
            else              d_left = $urandom_range(0, d_max);
         end
         if (d_left > 0) begin
            dmem_ready = 1'b0;
            d_left--;
            waits++;
         end else begin
            dmem_ready = 1'b1;
            dmem_rdata = dmem[dmem_addr[7:0]];
         end
      end else begin
         d_left = -1;
         dmem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         dmem_rdata = noise ? 16'($urandom()) : 16'h0;
      end
      if (dmem_req) dreq_len++;
      else if (dreq_len > 0) begin
         dlens.push_back(dreq_len);
         dreq_len = 0;
      end
   end

   always @(posedge clk) begin
      if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr[7:0]] = dmem_wdata;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      pc_reset = 1'b1;
      @(negedge clk);
      pc_reset = 1'b0;
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
   endtask

   task automatic start(input logic [15:0] init);
      @(negedge clk);
      initial_input = init;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic wait_halt(output int cyc);
      cyc = 0;
      while (!halted && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 16'hE000;
   endtask

   // Instruction-set model: executes the program in imem, counts base cycles.
   task automatic model_run(input logic [15:0] init);
      logic [15:0] pc, pc1, ir, a, b, s4, s8, addr, wv;
      int  wd, steps;
      bit  wen, done;
      m_reg[1] = init;
      pc = '0; m_cycles = 0; done = 1'b0; steps = 0;
      while (!done && steps < 2000) begin
         ir = imem[pc[7:0]];
         pc1 = pc + 16'd1;
         a = m_reg[ir[11:8]];
         b = m_reg[ir[7:4]];
         s4 = {{12{ir[3]}}, ir[3:0]};
         s8 = {{8{ir[11]}}, ir[11:4]};
         addr = a + s4;
         wen = 1'b0; wd = 0; wv = '0;
         case (ir[15:12])
            4'h0: begin wen = 1; wd = ir[3:0]; wv = a + b; m_cycles += 4; pc = pc1; end
            4'h1: begin wen = 1; wd = ir[3:0]; wv = a - b; m_cycles += 4; pc = pc1; end
            4'h2: begin wen = 1; wd = ir[3:0]; wv = a & b; m_cycles += 4; pc = pc1; end
            4'h3: begin wen = 1; wd = ir[3:0]; wv = a | b; m_cycles += 4; pc = pc1; end
            4'h4: begin wen = 1; wd = ir[7:4]; wv = a + s4; m_cycles += 4; pc = pc1; end
            4'h5: begin wen = 1; wd = ir[7:4]; wv = a << ir[3:0]; m_cycles += 4; pc = pc1; end
            4'h6: begin wen = 1; wd = ir[7:4]; wv = a >> ir[3:0]; m_cycles += 4; pc = pc1; end
            4'h7: begin wen = 1; wd = ir[7:4]; wv = m_mem[addr[7:0]]; m_cycles += 5; pc = pc1; end
            4'h8: begin m_mem[addr[7:0]] = b; m_cycles += 4; pc = pc1; end
            4'h9: begin pc = (a == b) ? pc1 + s4 : pc1; m_cycles += 3; end
            4'hA: begin pc = {pc1[15:12], ir[11:0]}; m_cycles += 3; end
            4'hB: begin wen = 1; wd = ir[3:0]; wv = pc1; pc = pc1 + s8; m_cycles += 4; end
            4'hC: begin pc = a; m_cycles += 3; end
            4'hD: begin done = 1'b1; m_cycles += 3; end
            default: begin m_cycles += 3; pc = pc1; end
         endcase
         if (wen && wd != 0) m_reg[wd] = wv;
         steps++;
      end
   endtask

   initial begin
      int cyc, n, bad;
      logic [3:0]  op;
      logic [31:0] rnd;
      logic [15:0] init;

      clear_imem();
      for (int i = 0; i < 256; i++) dmem[i] = '0;
      for (int i = 0; i < 16; i++) begin imem32[i] = 16'hE000; m_reg[i] = '0; end
      d_fixed = 0;
      repeat (2) @(negedge clk);
      check("rst_imem_req", imem_req, 0);
      check("rst_dmem_req", dmem_req, 0);
      check("rst_dmem_we", dmem_we, 0);
      check("rst_halted", halted, 0);
      check("rst_busy", busy, 0);
      check("rst_result", result_reg, 0);
      check("rst_pc", imem_addr, 0);
      pc_reset = 1'b0;

      // 32-bit wraparound add
      imem32[0] = 16'h4031; imem32[1] = 16'h0132; imem32[2] = 16'hD000;
      @(negedge clk); init32 = 32'hFFFF_FFFF; run32 = 1'b1;
      @(negedge clk); run32 = 1'b0;
      n = 0;
      while (!halted32 && n < 100) begin @(negedge clk); n++; end
      check("w32_cycles", n, 11);
      check("w32_result", result32, 32'h0);
      check("w32_halted", halted32, 1);

      // addi + halt, zero wait states
      imem[0] = 16'h4123; imem[1] = 16'hD000;
      start(16'd5);
      check("fetch_req", imem_req, 1);
      check("fetch_addr", imem_addr, 0);
      check("fetch_busy", busy, 1);
      wait_halt(cyc);
      check("addi_cycles", cyc, 7);
      check("addi_result", result_reg, 16'd8);
      check("addi_halted", halted, 1);

      // store/load with three data wait states each
      clear_imem();
      imem[0] = 16'h8014; imem[1] = 16'h7024; imem[2] = 16'hD000;
      d_fixed = 3;
      dlens.delete();
      start(16'h1234);
      wait_halt(cyc);
      check("ldst_cycles", cyc, 18);
      check("ldst_result", result_reg, 16'h1234);
      check("ldst_mem", dmem[4], 16'h1234);
      check("ldst_naccess", dlens.size(), 2);
      if (dlens.size() == 2) begin
         check("str_req_len", dlens[0], 4);
         check("ldr_req_len", dlens[1], 4);
      end
      d_fixed = 0;

      // beq taken backwards at pc=5
      do_reset();
      clear_imem();
      imem[5] = 16'h900E;
      start(16'd0);
      repeat (18) @(negedge clk);
      check("beq_req", imem_req, 1);
      check("beq_addr", imem_addr, 16'd4);
      repeat (3) @(negedge clk);
      check("nop_addr", imem_addr, 16'd5);

      // bl at pc=0
      do_reset();
      clear_imem();
      imem[0] = 16'hB0A2; imem[11] = 16'hD000;
      start(16'd0);
      repeat (4) @(negedge clk);
      check("bl_addr", imem_addr, 16'd11);
      check("bl_link", result_reg, 16'd1);
      repeat (3) @(negedge clk);
      check("bl_halt", halted, 1);

      // b, br, add, untaken beq
      clear_imem();
      imem[0] = 16'hA00A; imem[10] = 16'h4047; imem[11] = 16'hC400;
      imem[7] = 16'h0442; imem[8] = 16'h9405; imem[9] = 16'hD000;
      start(16'd0);
      wait_halt(cyc);
      check("br_cycles", cyc, 20);
      check("br_result", result_reg, 16'd14);

      // reset in the middle of a store
      do_reset();
      clear_imem();
      dmem[4] = 16'h1111;
      imem[0] = 16'h8014;
      d_fixed = 10;
      start(16'hBEEF);
      n = 0;
      while (!dmem_req && n < 20) begin @(negedge clk); n++; end
      check("mem_entry", dmem_req, 1);
      repeat (2) @(negedge clk);
      pc_reset = 1'b1;
      #1;
      check("abort_dmem_req", dmem_req, 0);
      check("abort_busy", busy, 0);
      check("abort_pc", imem_addr, 0);
      check("abort_result", result_reg, 0);
      @(negedge clk);
      pc_reset = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_mem", dmem[4], 16'h1111);
      check("abort_idle", busy, 0);
      d_fixed = 0;

      // run while busy is ignored, restart after halt reloads r1
      clear_imem();
      imem[0] = 16'h4121; imem[1] = 16'hD000;
      start(16'd10);
      @(negedge clk);
      initial_input = 16'd99; run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      wait_halt(cyc);
      check("busy_run_cycles", cyc + 2, 7);
      check("busy_run_result", result_reg, 16'd11);
      start(16'd20);
      check("restart_addr", imem_addr, 0);
      wait_halt(cyc);
      check("restart_cycles", cyc, 7);
      check("restart_result", result_reg, 16'd21);

      // random programs with random wait states and bus noise
      do_reset();
      noise = 1'b1; i_max = 3; d_max = 3; d_fixed = -1;
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 256; i++) begin dmem[i] = 16'($urandom()); m_mem[i] = dmem[i]; end
         clear_imem();
         for (int k = 0; k < 12; k++) begin
            n = $urandom_range(0, 10);
            op = (n <= 8) ? 4'(n) : ((n == 9) ? 4'hE : 4'hF);
            rnd = $urandom();
            imem[k] = {op, rnd[11:0]};
         end
         rnd = $urandom();
         imem[12] = {4'h0, rnd[7:0], 4'h2};
         imem[13] = 16'hD000;
         init = 16'($urandom());
         waits = 0;
         start(init);
         model_run(init);
         wait_halt(cyc);
         check("rnd_halted", halted, 1);
         check("rnd_cycles", cyc, m_cycles + waits);
         check("rnd_result", result_reg, m_reg[2]);
         bad = 0;
         for (int i = 0; i < 256; i++) if (dmem[i] !== m_mem[i]) bad++;
         check("rnd_dmem_diffs", bad, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_mc_param.md
CPU_MC_PARAM -- requirements
Module: cpu_mc_param

Interface
REQ-001 Parameter DATA_W, default 16, register/ALU/data-bus width; legal range 16..32.
REQ-002 Parameter PC_W, default 16, instruction address width; legal range 12..16.
REQ-003 Parameter DA_W, default 16, data-memory address width, at most DATA_W.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 pc_reset  in  1  reset, asynchronous, active-high.
REQ-006 run  in  1  start pulse; honoured only in IDLE or HALT.
REQ-007 initial_input  in  DATA_W  copied into r1 when run is accepted.
REQ-008 imem_req  out  1  instruction fetch request.
REQ-009 imem_addr  out  PC_W  fetch address, equal to pc.
REQ-010 imem_rdata  in  16  instruction word.
REQ-011 imem_ready  in  1  fetch complete; imem_rdata valid in the same cycle.
REQ-012 dmem_req  out  1  data access request.
REQ-013 dmem_we  out  1  1 = store, 0 = load.
REQ-014 dmem_addr  out  DA_W  data address.
REQ-015 dmem_wdata  out  DATA_W  store data.
REQ-016 dmem_rdata  in  DATA_W  load data.
REQ-017 dmem_ready  in  1  data access complete.
REQ-018 result_reg  out  DATA_W  continuous copy of r2.
REQ-019 halted  out  1  high in HALT state.
REQ-020 busy  out  1  high in any state other than IDLE and HALT.

Function
REQ-021 The block SHALL have 16 registers of DATA_W bits; r0 SHALL read 0 and SHALL ignore writes.
REQ-022 Encoding SHALL be: op=[15:12], rs=[11:8], rt=[7:4], rd=[3:0], imm4=sext([3:0]), imm8=sext([11:4]).
- Sign extension SHALL be to DATA_W for data and to PC_W for branches.
REQ-023 Opcodes SHALL be:
- 0 add rd=rs+rt; 1 sub rd=rs-rt; 2 and; 3 or
- 4 addi rt=rs+imm4
- 5 lsl rt=rs<<[3:0]; 6 lsr rt=rs>>[3:0] (logical)
- 7 ldr rt=mem[rs+imm4]; 8 str mem[rs+imm4]=rt
- 9 beq: if rs==rt, pc=pc+1+imm4
- A b: pc={pc_plus_1[PC_W-1:12], instr[11:0]}
- B bl: rd=pc+1 (zero-extended), pc=pc+1+imm8
- C br: pc=rs[PC_W-1:0]
- D halt; E,F nop
REQ-024 Arithmetic SHALL wrap modulo 2^DATA_W; pc SHALL wrap modulo 2^PC_W.
- The pc+1 increment SHALL wrap to 0 at the top of the PC_W address space.
REQ-025 The state machine SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-026 IDLE/HALT + run=1 -> FETCH; on this transition r1<=initial_input and pc<=0.
REQ-027 FETCH SHALL hold imem_req=1 with imem_addr=pc.
- On an edge with imem_ready=1, the block SHALL latch the instruction and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-028 DECODE SHALL read rs and rt into operand latches, then go to EXEC.
REQ-029 EXEC SHALL compute the ALU result or branch target, then transition:
- ldr/str -> MEM
- ALU ops and bl -> WB
- b/br/beq/nop -> FETCH with pc updated
- halt -> HALT
REQ-030 MEM SHALL hold dmem_req=1 with dmem_addr=alu[DA_W-1:0], dmem_we, and dmem_wdata=rt stable until dmem_ready=1.
- On completion: load -> WB latching dmem_rdata; store -> FETCH.
REQ-031 WB SHALL write the destination register and set pc<=pc+1 (bl sets pc<=target), then go to FETCH.
REQ-032 Non-branch instructions SHALL set pc<=pc+1 on leaving their final state; a not-taken beq SHALL also set pc<=pc+1.
REQ-033 With zero wait states the cycle counts SHALL be:
- 4 cycles for ALU ops and bl
- 5 cycles for ldr
- 4 cycles for str
- 3 cycles for b/br/beq/nop/halt
REQ-034 Each wait cycle (ready=0) SHALL add exactly one cycle; req SHALL be 0 in all other states.
REQ-035 run while busy SHALL be ignored; imem_ready/dmem_ready outside FETCH/MEM SHALL be ignored.
REQ-036 result_reg SHALL reflect a write to r2 on the cycle after the WB edge.

Reset
REQ-037 pc_reset=1 SHALL immediately force:
- state=IDLE, pc=0, all registers 0
- imem_req=dmem_req=dmem_we=0, halted=0, busy=0
- result_reg=0
REQ-038 Reset mid-access SHALL abandon the transaction; no register or pc update SHALL occur from it.

Verification
REQ-039 DATA_W=16, initial_input=5, program addi r1->r2 imm=3, halt; ready tied 1 -> result_reg=8 and halted=1 after 7 cycles from FETCH entry.
REQ-040 DATA_W=32: add with r1=0xFFFFFFFF and r3=1 into r2 -> result_reg=0x00000000.
REQ-041 str r1=0x1234 to address 4, then ldr into r2; dmem_ready delayed 3 cycles each -> dmem_req held for 4 cycles per access; result_reg=0x1234.
REQ-042 beq r0,r0 imm=-2 at pc=5 -> next imem_addr=4; bl imm8=10 at pc=0 with rd=2 -> r2=1, next imem_addr=11.
REQ-043 pc_reset asserted during MEM with dmem_req=1 -> dmem_req=0 with no clock edge; state=IDLE; memory and registers unchanged.
REQ-044 run pulsed while busy -> ignored; after halt, run -> restart at pc=0 with r1 reloaded from initial_input.
